// File: rtl/seq_detect_param_if.sv
// Serial pattern detector bus: data/valid, configuration load and result outputs.
// The master side drives stimulus and configuration; the slave side is the detector.
interface seq_detect_param_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               en;
   logic               din;
   logic               cfg_load;
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   pat_len;
   logic               ovl;
   logic               flag;
   logic               cfg_err;
   logic [CNT_W-1:0]   match_cnt;

   modport master (
      output en, din, cfg_load, pat, pat_len, ovl,
      input  flag, cfg_err, match_cnt
   );

   modport slave (
      input  en, din, cfg_load, pat, pat_len, ovl,
      output flag, cfg_err, match_cnt
   );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector, all state on the falling clock edge.
// Matches a runtime-loadable pattern of 1..MAX_LEN bits, overlapping or not.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN;
// without it match_cnt is tied to zero.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  FILL  | fewer than len_q-1 bits collected; no match possible yet
//  HUNT  | enough history; every valid bit is a match candidate
module seq_detect_param #(
   parameter int                 MAX_LEN = 8,
   parameter int                 LEN_W   = 4,
   parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(3'b110),
   parameter int                 DEF_LEN = 3,
   parameter int                 CNT_W   = 8
) (
   input logic              clk,
   input logic              rst_n,
   seq_detect_param_if.slave bus
);

   typedef enum logic {FILL = 1'b0, HUNT = 1'b1} state_t;

   localparam int FW = LEN_W + 1;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] hist_q, hist_d, hist_next, mask, pat_q, pat_d;
   logic [LEN_W-1:0]   fill_q, fill_d, fill_sat, len_q, len_d;
   logic [FW-1:0]      fill_p1;
   logic               ovl_q, ovl_d;
   logic               flag_q, flag_d, err_q, err_d;
   logic               hit, cfg_valid;

   // Shared datapath terms: candidate history, length mask, fill arithmetic.
   always_comb begin
      hist_next = {hist_q[MAX_LEN-2:0], bus.din};
      fill_p1   = {1'b0, fill_q} + FW'(1);
      fill_sat  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
      cfg_valid = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(MAX_LEN));
      mask      = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
   end

   // Next-state, history and configuration update; cfg_load outranks en.
   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      flag_d  = 1'b0;
      err_d   = 1'b0;
      hit     = 1'b0;
      if (bus.cfg_load) begin
         if (cfg_valid) begin
            pat_d   = bus.pat;
            len_d   = bus.pat_len;
            ovl_d   = bus.ovl;
            hist_d  = '0;
            fill_d  = '0;
            // A one-bit pattern needs no history, so it lives in HUNT.
            state_d = (bus.pat_len == LEN_W'(1)) ? HUNT : FILL;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.en) begin
         hit    = (fill_p1 >= {1'b0, len_q}) && ((hist_next & mask) == (pat_q & mask));
         flag_d = hit;
         case (state_q)
            FILL: begin
               hist_d = hist_next;
               fill_d = fill_sat;
               if ((fill_p1 + FW'(1)) >= {1'b0, len_q}) state_d = HUNT;
            end
            HUNT: begin
               if (hit && !ovl_q) begin
                  hist_d  = '0;
                  fill_d  = '0;
                  state_d = (len_q == LEN_W'(1)) ? HUNT : FILL;
               end else begin
                  hist_d = hist_next;
                  fill_d = fill_sat;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   // State and configuration registers with synchronous active-low reset.
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         state_q <= (DEF_LEN == 1) ? HUNT : FILL;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= DEF_PAT;
         len_q   <= LEN_W'(DEF_LEN);
         ovl_q   <= 1'b1;
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
      end
   end

   assign bus.flag    = flag_q;
   assign bus.cfg_err = err_q;

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_clr;

   assign cnt_clr = bus.cfg_load && cfg_valid;

   // Saturating hit counter, cleared by reset and by an accepted reconfiguration.
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (hit && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.match_cnt = cnt_q;
`else
   assign bus.match_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param; outputs sampled on the rising edge,
// half a period after the falling active edge.
module tb_seq_detect_param;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;

   logic clk = 1'b1;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   exp_cnt = 0;

   seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int cnt_expect();
`ifdef SEQ_DET_CNT_EN
      return exp_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic tick();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic step(input string tag, input logic e, input logic d, input logic exp_f);
      rst_n = 1'b1;
      bus.cfg_load = 1'b0;
      bus.en = e;
      bus.din = d;
      tick();
      if (exp_f && exp_cnt < 3) exp_cnt++;
      check({tag, ".flag"}, 32'(bus.flag), 32'(exp_f));
      check({tag, ".err"}, 32'(bus.cfg_err), 0);
      check({tag, ".cnt"}, 32'(bus.match_cnt), cnt_expect());
   endtask

   task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic exp_err);
      rst_n = 1'b1;
      bus.cfg_load = 1'b1;
      bus.en = 1'b1;
      bus.din = 1'b1;
      bus.pat = p;
      bus.pat_len = l;
      bus.ovl = o;
      tick();
      if (!exp_err) exp_cnt = 0;
      check({tag, ".flag"}, 32'(bus.flag), 0);
      check({tag, ".err"}, 32'(bus.cfg_err), 32'(exp_err));
      check({tag, ".cnt"}, 32'(bus.match_cnt), cnt_expect());
      bus.cfg_load = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      bus.cfg_load = 1'b1;
      bus.pat_len = 4'd0;
      bus.en = 1'b1;
      bus.din = 1'b1;
      tick();
      exp_cnt = 0;
      check({tag, ".flag"}, 32'(bus.flag), 0);
      check({tag, ".err"}, 32'(bus.cfg_err), 0);
      check({tag, ".cnt"}, 32'(bus.match_cnt), 0);
      bus.cfg_load = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.din = 1'b0;
      bus.cfg_load = 1'b0;
      bus.pat = '0;
      bus.pat_len = '0;
      bus.ovl = 1'b1;
      do_reset("rst0");
      do_reset("rst1");

      // default pattern 110
      step("d1", 1, 1, 0);
      step("d2", 1, 1, 0);
      step("d3", 1, 0, 1);
      step("d4", 1, 1, 0);
      step("d5", 1, 1, 0);
      step("d6", 1, 1, 0);
      step("d7", 1, 0, 1);

      // 1010 overlapping
      load("ovl_ld", 8'b1010, 4'd4, 1'b1, 1'b0);
      step("o1", 1, 1, 0);
      step("o2", 1, 0, 0);
      step("o3", 1, 1, 0);
      step("o4", 1, 0, 1);
      step("o5", 1, 1, 0);
      step("o6", 1, 0, 1);

      // 1010 non-overlapping
      load("nov_ld", 8'b1010, 4'd4, 1'b0, 1'b0);
      step("n1", 1, 1, 0);
      step("n2", 1, 0, 0);
      step("n3", 1, 1, 0);
      step("n4", 1, 0, 1);
      step("n5", 1, 1, 0);
      step("n6", 1, 0, 0);

      // en gating
      load("en_ld", 8'b110, 4'd3, 1'b1, 1'b0);
      step("g1", 1, 1, 0);
      step("g2", 0, 0, 0);
      step("g3", 1, 1, 0);
      step("g4", 1, 0, 1);

      // rejected lengths keep config and history
      load("bad0", 8'b1, 4'd0, 1'b0, 1'b1);
      load("bad9", 8'b1, 4'd9, 1'b0, 1'b1);
      step("k1", 1, 1, 0);
      step("k2", 1, 1, 0);
      step("k3", 1, 0, 1);

      // one-bit pattern
      load("l1_ld", 8'b1, 4'd1, 1'b1, 1'b0);
      step("s1", 1, 1, 1);
      step("s2", 1, 1, 1);
      step("s3", 1, 0, 0);
      load("l1n_ld", 8'b1, 4'd1, 1'b0, 1'b0);
      step("s4", 1, 1, 1);
      step("s5", 1, 1, 1);

      // full-width pattern
      load("l8_ld", 8'b10110011, 4'd8, 1'b1, 1'b0);
      step("f1", 1, 1, 0);
      step("f2", 1, 0, 0);
      step("f3", 1, 1, 0);
      step("f4", 1, 1, 0);
      step("f5", 1, 0, 0);
      step("f6", 1, 0, 0);
      step("f7", 1, 1, 0);
      step("f8", 1, 1, 1);
      step("f9", 1, 0, 0);

      // reset mid-sequence discards partial history
      load("r_ld", 8'b110, 4'd3, 1'b1, 1'b0);
      step("r1", 1, 1, 0);
      step("r2", 1, 1, 0);
      do_reset("rst_mid");
      step("r3", 1, 0, 0);
      step("r4", 1, 1, 0);
      step("r5", 1, 1, 0);
      step("r6", 1, 0, 1);

      // counter saturation (match_cnt 1,2,3,3,3 when enabled)
      step("c1", 1, 1, 0);
      step("c2", 1, 1, 0);
      step("c3", 1, 0, 1);
      step("c4", 1, 1, 0);
      step("c5", 1, 1, 0);
      step("c6", 1, 0, 1);
      step("c7", 1, 1, 0);
      step("c8", 1, 1, 0);
      step("c9", 1, 0, 1);
      step("c10", 1, 1, 0);
      step("c11", 1, 1, 0);
      step("c12", 1, 0, 1);
      load("c_ld", 8'b110, 4'd3, 1'b1, 1'b0);
      step("c13", 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
